// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, using one
// full-subtractor cell and a borrow flop. Optional ovf port via SUB_OVERFLOW_FLAG_EN.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done,
`ifdef SUB_OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic load, step, last;
  logic d_bit, borrow_nxt;

`ifdef SUB_OVERFLOW_FLAG_EN
  logic a_msb, b_msb;
`endif

  // Handshake: start is a request accepted only in IDLE (ignored otherwise, never queued);
  // done is a one-cycle strobe marking diff/bout valid, and they hold until the next accept.

  // Single full-subtractor cell on the current LSBs.
  assign d_bit      = sa[0] ^ sb[0] ^ borrow;
  assign borrow_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
  assign last       = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (load) begin
      sa     <= a;
      sb     <= b;
      borrow <= bin;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (step) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      borrow <= borrow_nxt;
      diff   <= {d_bit, diff[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      if (last) bout <= borrow_nxt;
    end
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  // Signed overflow: operand signs differ and the result sign differs from the minuend's.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      ovf   <= 1'b0;
    end else if (step && last) begin
      ovf <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (WIDTH=8): randomized and directed
// operations scored against an arithmetic model of a - b - bin.
module tb_bit_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic             ovf;
  logic             ovf_q[$];
  logic             hold_ovf = 1'b0;
`endif

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] hold_val = '0;
  int             n_checks = 0;
  int             n_pass = 0;
  int             busy_run = 0;
  logic           prev_done = 1'b0;

  bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy),
    .done      (done),
`ifdef SUB_OVERFLOW_FLAG_EN
    .ovf       (ovf),
`endif
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: borrow-extended subtraction, {bout,diff} = {0,a} - b - bin.
  function automatic logic [WIDTH:0] model_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic bi);
    int unsigned r;
    r = int'(x) - int'(y) - int'(bi);
    return r[WIDTH:0];
  endfunction

  function automatic logic model_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH:0] res);
    return (x[WIDTH-1] != y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Compare process: every non-reset cycle, checks results on done and held outputs in idle.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        busy_run++;
        check("run_has_owner", 64'(exp_q.size()), 64'd1);
      end
      if (done) begin
        check("single_done_pulse", 64'(prev_done), 64'd0);
        check("busy_len", 64'(busy_run), 64'(WIDTH));
        check("queue_at_done", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("result", 64'({bout, diff}), 64'(e));
          hold_val = e;
`ifdef SUB_OVERFLOW_FLAG_EN
          hold_ovf = ovf_q.pop_front();
          check("ovf", 64'(ovf), 64'(hold_ovf));
`endif
        end
        busy_run = 0;
      end else if (!busy) begin
        check("held_result", 64'({bout, diff}), 64'(hold_val));
`ifdef SUB_OVERFLOW_FLAG_EN
        check("held_ovf", 64'(ovf), 64'(hold_ovf));
`endif
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    logic got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && !done) begin
        got = 1'b1;
        break;
      end
    end
    check("idle_reached", 64'(got), 64'd1);
  endtask

  // One operation; s1/s2 are RUN cycles (1-based) on which a stray start is driven.
  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xbin,
                        input int s1, input int s2);
    logic [WIDTH:0] r;
    wait_idle();
    a = xa; b = xb; bin = xbin; start = 1'b1;
    r = model_sub(xa, xb, xbin);
    exp_q.push_back(r);
`ifdef SUB_OVERFLOW_FLAG_EN
    ovf_q.push_back(model_ovf(xa, xb, r));
`endif
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= WIDTH; cyc++) begin
      start = (cyc == s1) || (cyc == s2);
      a = (s1 != 0) ? WIDTH'(99) : WIDTH'($urandom);
      b = WIDTH'($urandom);
      bin = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    check("done_latency", 64'(done), 64'd1);
  endtask

  task automatic check_lit(input string name, input logic [WIDTH:0] v);
    @(negedge clk);
    check(name, 64'({bout, diff}), 64'(v));
  endtask

  task automatic run_abort(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
    wait_idle();
    a = xa; b = xb; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model_sub(xa, xb, 1'b0));
`ifdef SUB_OVERFLOW_FLAG_EN
    ovf_q.push_back(1'b0);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    hold_val = '0;
`ifdef SUB_OVERFLOW_FLAG_EN
    ovf_q.delete();
    hold_ovf = 1'b0;
`endif
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_outputs", 64'({bout, diff}), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_outputs", 64'({bout, diff}), 64'd0);

    run_op(8'd200, 8'd55, 1'b0, 0, 0);
    check_lit("lit_200_55", 9'h091);
    run_op(8'd55, 8'd200, 1'b0, 0, 0);
    check_lit("lit_55_200", 9'h16F);
    run_op(8'd0, 8'd0, 1'b1, 0, 0);
    check_lit("lit_0_0_1", 9'h1FF);
    run_op(8'd10, 8'd3, 1'b0, 3, 8);
    check_lit("lit_ignored_start", 9'h007);
    run_abort(8'd10, 8'd3);
    run_op(8'd9, 8'd4, 1'b0, 0, 0);
    check_lit("lit_after_abort", 9'h005);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 0);
    check_lit("lit_ff_ff_1", 9'h1FF);
    run_op(8'hFF, 8'h00, 1'b0, 0, 0);
    check_lit("lit_ff_00", 9'h0FF);
`ifdef SUB_OVERFLOW_FLAG_EN
    run_op(8'h80, 8'h01, 1'b0, 0, 0);
    @(negedge clk);
    check("lit_ovf_80_01", 64'({ovf, bout, diff}), 64'(10'h27F));
    run_op(8'h05, 8'h03, 1'b0, 0, 0);
    @(negedge clk);
    check("lit_ovf_05_03", 64'({ovf, bout, diff}), 64'(10'h002));
`endif

    for (int n = 0; n < 1500; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 0);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
